// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR band scheduler and its tap counter.
// State encodings stay as plain constants so older band wrappers can reuse them.
package fir_sched_pkg;

    localparam int PTR_W    = 10;
    localparam int DEF_TAPS = 1021;
    localparam int DEF_PIPE = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RES   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CLR   = S_CLR,
        ST_RUN   = S_RUN,
        ST_DRAIN = S_DRAIN,
        ST_RES   = S_RES,
        ST_DONE  = S_DONE
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_band(input logic [7:0] mask);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fir_tap_cnt.sv
// Coefficient address counter: clears, steps while enabled and wraps after TAPS-1.
module fir_tap_cnt
    import fir_sched_pkg::*;
#(
    parameter int TAPS = DEF_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [PTR_W-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == PTR_W'(TAPS - 1));

    // Wrapping at terminal count leaves the address at 0 once the sweep ends.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + PTR_W'(1);
        end
    end

endmodule

// File: rtl/fir_band_sched.sv
// Time-multiplexes one FIR core and coefficient ROM across NUM_BANDS bands,
// sweeping every enabled band once per accepted sample in ascending order.
module fir_band_sched
    import fir_sched_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int TAPS      = DEF_TAPS,
    parameter int PIPE      = DEF_PIPE,
    localparam int BW       = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 smpl_vld,
    input  logic [NUM_BANDS-1:0] band_en,
    input  logic                 ovr_clr,
    output logic                 sequencing,
    output logic [PTR_W-1:0]     cff_ptr,
    output logic [BW-1:0]        band_sel,
    output logic                 acc_clr,
    output logic                 res_vld,
    output logic [BW-1:0]        res_band,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    state_t               state, nxt;
    logic [NUM_BANDS-1:0] pend, pend_nxt, sel_mask;
    logic [BW-1:0]        sel_nxt;
    logic [7:0]           dcnt;
    logic                 tc, ovr_set;

    assign sel_mask = NUM_BANDS'(1) << band_sel;

    fir_tap_cnt #(.TAPS(TAPS)) u_tap_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == ST_CLR),
        .en  (state == ST_RUN),
        .cnt (cff_ptr),
        .tc  (tc)
    );

    always_comb begin
        nxt      = state;
        pend_nxt = pend;
        sel_nxt  = band_sel;
        ovr_set  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                nxt     = ST_IDLE;
                sel_nxt = '0;
                if (smpl_vld) begin
                    pend_nxt = band_en;
                    if (band_en != '0) begin
                        nxt     = ST_CLR;
                        sel_nxt = BW'(lowest_band(8'(band_en)));
                    end else begin
                        nxt = ST_DONE;
                    end
                end
            end
            ST_CLR: nxt = ST_RUN;
            ST_RUN: if (tc) nxt = ST_DRAIN;
            ST_DRAIN: if (dcnt == 8'(PIPE - 1)) nxt = ST_RES;
            ST_RES: begin
                pend_nxt = pend & ~sel_mask;
                if (pend_nxt != '0) begin
                    nxt     = ST_CLR;
                    sel_nxt = BW'(lowest_band(8'(pend_nxt)));
                end else begin
                    nxt     = ST_DONE;
                    sel_nxt = '0;
                end
            end
            default: nxt = ST_IDLE;
        endcase
        // A sample arriving mid-sweep is dropped; only the flag records it.
        if (state != ST_IDLE && state != ST_DONE) ovr_set = smpl_vld;
    end

    // Outputs are decoded from the next state so they align with it in one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pend       <= '0;
            dcnt       <= '0;
            band_sel   <= '0;
            sequencing <= 1'b0;
            acc_clr    <= 1'b0;
            res_vld    <= 1'b0;
            res_band   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= nxt;
            pend       <= pend_nxt;
            dcnt       <= (state == ST_DRAIN) ? dcnt + 8'd1 : 8'd0;
            band_sel   <= sel_nxt;
            sequencing <= (nxt == ST_RUN);
            acc_clr    <= (nxt == ST_CLR);
            res_vld    <= (nxt == ST_RES);
            res_band   <= (nxt == ST_RES) ? sel_nxt : '0;
            busy       <= (nxt == ST_CLR) || (nxt == ST_RUN) ||
                          (nxt == ST_DRAIN) || (nxt == ST_RES);
            done       <= (nxt == ST_DONE);
            overrun    <= ovr_set || (overrun && !ovr_clr);
        end
    end

endmodule

// File: tb/tb_fir_band_sched.sv
// Directed bench for fir_band_sched with TAPS=8, PIPE=2, four bands.
module tb_fir_band_sched;

    localparam int NB   = 4;
    localparam int TP   = 8;
    localparam int PP   = 2;
    localparam int PER  = TP + PP + 2;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          smpl_vld = 1'b0;
    logic [NB-1:0] band_en = '0;
    logic          ovr_clr = 1'b0;
    logic          sequencing, acc_clr, res_vld, busy, done, overrun;
    logic [9:0]    cff_ptr;
    logic [1:0]    band_sel, res_band;

    fir_band_sched #(.NUM_BANDS(NB), .TAPS(TP), .PIPE(PP)) dut (
        .clk        (clk),
        .rst        (rst),
        .smpl_vld   (smpl_vld),
        .band_en    (band_en),
        .ovr_clr    (ovr_clr),
        .sequencing (sequencing),
        .cff_ptr    (cff_ptr),
        .band_sel   (band_sel),
        .acc_clr    (acc_clr),
        .res_vld    (res_vld),
        .res_band   (res_band),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic       t_seq [MAXC];
    logic       t_acc [MAXC];
    logic       t_rv  [MAXC];
    logic       t_dn  [MAXC];
    logic       t_ovr [MAXC];
    logic       t_bsy [MAXC];
    logic [9:0] t_ptr [MAXC];
    logic [1:0] t_bs  [MAXC];
    logic [1:0] t_rb  [MAXC];

    typedef struct {
        logic [NB-1:0] en;
        int            nres;
        int            done_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Runs ncyc cycles from just after a rising edge; cycle c is recorded at its falling edge.
    task automatic run(input logic [NB-1:0] en, input logic [NB-1:0] en2, input int ncyc,
                       input int v1, input int v2, input int clr_c, input int rst_c);
        for (int c = 0; c < ncyc; c++) begin
            smpl_vld = (c == v1) || (c == v2);
            band_en  = (c == 0) ? en : en2;
            ovr_clr  = (c == clr_c);
            rst      = (c == rst_c);
            @(negedge clk);
            t_seq[c] = sequencing; t_acc[c] = acc_clr; t_rv[c] = res_vld;
            t_dn[c]  = done;       t_ovr[c] = overrun; t_bsy[c] = busy;
            t_ptr[c] = cff_ptr;    t_bs[c]  = band_sel; t_rb[c] = res_band;
            @(posedge clk);
            #1;
        end
        smpl_vld = 1'b0;
        ovr_clr  = 1'b0;
        rst      = 1'b0;
    endtask

    function automatic int count_rv(input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) if (t_rv[c]) n++;
        return n;
    endfunction

    function automatic int count_dn(input int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) if (t_dn[c]) n++;
        return n;
    endfunction

    initial begin
        int nz, k, nseq, bad, ramp;

        vecs[0] = '{en: 4'b1111, nres: 4, done_cyc: 49};
        vecs[1] = '{en: 4'b0101, nres: 2, done_cyc: 25};
        vecs[2] = '{en: 4'b0000, nres: 0, done_cyc: 1};
        vecs[3] = '{en: 4'b1000, nres: 1, done_cyc: 13};
        vecs[4] = '{en: 4'b0110, nres: 2, done_cyc: 25};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        run('0, '0, 20, -1, -1, -1, -1);
        nz = 0;
        for (int c = 0; c < 20; c++) begin
            if (t_seq[c] || t_acc[c] || t_rv[c] || t_dn[c] || t_ovr[c] || t_bsy[c] ||
                t_ptr[c] != 0 || t_bs[c] != 0 || t_rb[c] != 0) nz++;
        end
        check("reset_idle_nonzero_cycles", nz, 0);
        check("reset_busy", int'(t_bsy[19]), 0);

        for (int v = 0; v < 5; v++) begin
            run(vecs[v].en, vecs[v].en, 60, 0, -1, -1, -1);
            check($sformatf("v%0d_res_count", v), count_rv(60), vecs[v].nres);
            check($sformatf("v%0d_done_count", v), count_dn(60), 1);
            check($sformatf("v%0d_done_at", v), int'(t_dn[vecs[v].done_cyc]), 1);
            k = 0;
            for (int b = 0; b < NB; b++) begin
                if (vecs[v].en[b]) begin
                    check($sformatf("v%0d_acc_clr_b%0d", v, b), int'(t_acc[PER*k + 1]), 1);
                    check($sformatf("v%0d_res_vld_b%0d", v, b), int'(t_rv[PER*(k+1)]), 1);
                    check($sformatf("v%0d_res_band_b%0d", v, b), int'(t_rb[PER*(k+1)]), b);
                    k++;
                end
            end
            nseq = 0; bad = 0; ramp = 0;
            for (int c = 0; c < 60; c++) begin
                if (t_seq[c]) nseq++;
                if (t_bsy[c] && !vecs[v].en[t_bs[c]]) bad++;
            end
            check($sformatf("v%0d_seq_cycles", v), nseq, TP * vecs[v].nres);
            check($sformatf("v%0d_foreign_band_sel", v), bad, 0);
            if (vecs[v].nres > 0) begin
                for (int i = 0; i < TP; i++)
                    if (!t_seq[2+i] || t_ptr[2+i] != 10'(i)) ramp++;
                if (t_ptr[2+TP] != 0 || t_seq[2+TP]) ramp++;
                check($sformatf("v%0d_cff_ptr_ramp_errs", v), ramp, 0);
            end
        end

        // Overrun while busy; the dropped sample carries a different band mask.
        run(4'b0001, 4'b1110, 20, 0, 5, -1, -1);
        check("ovr_before", int'(t_ovr[5]), 0);
        check("ovr_set", int'(t_ovr[6]), 1);
        check("ovr_sticky", int'(t_ovr[19]), 1);
        check("ovr_res_vld", int'(t_rv[12]), 1);
        check("ovr_res_band", int'(t_rb[12]), 0);
        check("ovr_done", int'(t_dn[13]), 1);
        check("ovr_res_count", count_rv(20), 1);

        run('0, '0, 3, -1, -1, 0, -1);
        check("ovr_clr_before", int'(t_ovr[0]), 1);
        check("ovr_clr_after", int'(t_ovr[1]), 0);

        // New sample accepted in the DONE cycle.
        run(4'b0001, 4'b0001, 30, 0, 13, -1, -1);
        check("done_acc_done", int'(t_dn[13]), 1);
        check("done_acc_clr", int'(t_acc[14]), 1);
        check("done_acc_busy", int'(t_bsy[14]), 1);
        check("done_acc_res2", int'(t_rv[25]), 1);
        check("done_acc_done2", int'(t_dn[26]), 1);
        check("done_acc_no_ovr", int'(t_ovr[20]), 0);

        // Reset in the middle of a sweep.
        run(4'b1111, 4'b1111, 30, 0, -1, -1, 6);
        check("rst_busy_before", int'(t_bsy[6]), 1);
        check("rst_busy_after", int'(t_bsy[7]), 0);
        check("rst_seq_after", int'(t_seq[7]), 0);
        check("rst_ptr_after", int'(t_ptr[7]), 0);
        check("rst_bsel_after", int'(t_bs[7]), 0);
        check("rst_no_res", count_rv(30), 0);
        check("rst_no_done", count_dn(30), 0);

        run(4'b0010, 4'b0010, 20, 0, -1, -1, -1);
        check("post_rst_res", int'(t_rv[12]), 1);
        check("post_rst_band", int'(t_rb[12]), 1);
        check("post_rst_done", int'(t_dn[13]), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
